// File: rtl/lowdec_pkg.sv
// Shared types and helpers for the active-low one-of-N select decoder.
package lowdec_pkg;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_DIRECT    = 2'b01,
    MODE_SCAN_UP   = 2'b10,
    MODE_SCAN_DOWN = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  // Callers truncate to their own output width.
  function automatic logic [63:0] onecold(input logic [5:0] i);
    return ~(64'd1 << i);
  endfunction

endpackage

// File: rtl/lowdec_dwell_timer.sv
// Dwell counter: counts while enabled, ticks when the count reaches the
// live dwell value, then restarts from zero.
module lowdec_dwell_timer
  import lowdec_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] cnt;

  assign tick = en && (cnt >= dwell);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lowdec_scan.sv
// Registered active-low one-of-N decoder with off, direct and
// up/down scan modes plus a wrap pulse.
module lowdec_scan
  import lowdec_pkg::*;
#(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   res,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  state_t           state, nxt_state;
  mode_t            m;
  logic [SEL_W-1:0] nxt_idx;
  logic             nxt_wrap;
  logic             tick;

  assign m = mode_t'(mode);

  lowdec_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!mode[1] || load),
    .en   (mode[1]),
    .dwell(dwell),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      idx   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      wrap  <= nxt_wrap;
    end
  end

  always_comb begin
    nxt_state = ST_OFF;
    nxt_idx   = idx;
    nxt_wrap  = 1'b0;
    unique case (1'b1)
      m == MODE_OFF: nxt_state = ST_OFF;
      m == MODE_DIRECT: begin
        nxt_state = ST_DIRECT;
        nxt_idx   = sel;
      end
      m == MODE_SCAN_UP,
      m == MODE_SCAN_DOWN: begin
        nxt_state = ST_SCAN;
        // load beats a pending advance and never wraps
        if (load) begin
          nxt_idx = sel;
        end else if (tick) begin
          if (mode[0]) begin
            nxt_idx  = idx - 1'b1;
            nxt_wrap = (idx == '0);
          end else begin
            nxt_idx  = idx + 1'b1;
            nxt_wrap = (idx == '1);
          end
        end
      end
      default: nxt_state = ST_OFF;
    endcase
  end

  // Decoded purely from registers, so no input reaches res in the same cycle.
  assign res = (state == ST_OFF) ? '1 : OUT_W'(onecold(6'(idx)));

endmodule

// File: tb/tb_lowdec_scan.sv
// Directed self-checking bench for lowdec_scan (SEL_W=3, DWELL_W=8).
module tb_lowdec_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       load;
  logic [7:0] dwell;
  logic [7:0] res;
  logic [2:0] idx;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_DIR = 2'b01;
  localparam logic [1:0] M_UP  = 2'b10;
  localparam logic [1:0] M_DN  = 2'b11;

  always #5 clk = ~clk;

  lowdec_scan #(
    .SEL_W  (3),
    .DWELL_W(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .load (load),
    .dwell(dwell),
    .res  (res),
    .idx  (idx),
    .wrap (wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] e_res,
                      input logic [2:0] e_idx, input logic e_wrap);
    chk({tag, ".res"}, 64'(res), 64'(e_res));
    chk({tag, ".idx"}, 64'(idx), 64'(e_idx));
    chk({tag, ".wrap"}, 64'(wrap), 64'(e_wrap));
  endtask

  logic [7:0] dir_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                              8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [2:0] up_idx [7] = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0};
  logic       up_wrp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // reset wins over mode/load
    rst = 1'b1; mode = M_DIR; sel = 3'd5; load = 1'b1; dwell = 8'd0;
    tick();
    chk3("reset", 8'hFF, 3'd0, 1'b0);

    rst = 1'b0; load = 1'b0;
    tick();
    chk3("direct5", 8'hDF, 3'd5, 1'b0);

    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      chk($sformatf("sweep%0d.res", s), 64'(res), 64'(dir_tab[s]));
    end

    sel = 3'd2;
    tick();
    mode = M_OFF;
    tick();
    chk3("off", 8'hFF, 3'd2, 1'b0);
    mode = M_DIR;
    tick();
    chk3("redirect2", 8'hFB, 3'd2, 1'b0);

    // scan up, dwell 2, from 6
    sel = 3'd6;
    tick();
    mode = M_UP; dwell = 8'd2;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("up%0d.idx", k), 64'(idx), 64'(up_idx[k]));
      chk($sformatf("up%0d.wrap", k), 64'(wrap), 64'(up_wrp[k]));
    end
    chk("up_wrapped.res", 64'(res), 64'(8'hFE));

    // scan down, dwell 0
    mode = M_DN; dwell = 8'd0; load = 1'b1; sel = 3'd1;
    tick();
    chk3("dn_load1", 8'hFD, 3'd1, 1'b0);
    load = 1'b0;
    tick();
    chk3("dn0", 8'hFE, 3'd0, 1'b0);
    tick();
    chk3("dn_wrap7", 8'h7F, 3'd7, 1'b1);
    tick();
    chk3("dn6", 8'hBF, 3'd6, 1'b0);
    load = 1'b1; sel = 3'd0;
    tick();
    chk3("dn_load0", 8'hFE, 3'd0, 1'b0);
    sel = 3'd4;
    tick();
    chk3("dn_load4", 8'hEF, 3'd4, 1'b0);
    load = 1'b0;
    tick();
    chk3("dn3", 8'hF7, 3'd3, 1'b0);

    // dwell lowered mid-dwell
    mode = M_UP; dwell = 8'd10; load = 1'b1; sel = 3'd2;
    tick();
    load = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk3("long_dwell", 8'hFB, 3'd2, 1'b0);
    dwell = 8'd3;
    tick();
    chk3("forced_adv", 8'hF7, 3'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold3_%0d.idx", k), 64'(idx), 64'(3'd3));
    end
    tick();
    chk3("adv4", 8'hEF, 3'd4, 1'b0);

    // direction flip mid-dwell keeps count
    tick();
    tick();
    mode = M_DN;
    tick();
    chk3("flip_hold", 8'hEF, 3'd4, 1'b0);
    tick();
    chk3("flip_adv", 8'hF7, 3'd3, 1'b0);

    // OFF then scan entry from held idx
    mode = M_OFF;
    tick();
    chk3("off2", 8'hFF, 3'd3, 1'b0);
    mode = M_UP; dwell = 8'd1;
    tick();
    chk3("entry_hold", 8'hF7, 3'd3, 1'b0);
    tick();
    chk3("entry_adv", 8'hEF, 3'd4, 1'b0);

    // reset mid-scan
    dwell = 8'd0; load = 1'b1; sel = 3'd5;
    tick();
    chk3("pre_rst5", 8'hDF, 3'd5, 1'b0);
    rst = 1'b1; sel = 3'd3;
    tick();
    chk3("rst_mid", 8'hFF, 3'd0, 1'b0);
    rst = 1'b0; load = 1'b0;
    tick();
    chk3("post_rst", 8'hFD, 3'd1, 1'b0);
    load = 1'b1; sel = 3'd7;
    tick();
    load = 1'b0; rst = 1'b1;
    tick();
    chk3("rst_at7", 8'hFF, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lowdec_scan.md
# lowdec_scan

Parametrised, registered active-low one-of-N select decoder with an autonomous scan mode. It generalises the fixed 3-to-8 active-low decoder to SEL_W select bits and adds a registered output, an off/blank mode, and up/down scanning with programmable dwell and wrap indication. It drives active-low enables for row/column strobes, chip-selects and test-pattern walkers in the combinational-test datapath.

## Interface
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived, not overridable); legal 1..6
- DWELL_W, 8, width of dwell programming field
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- mode  in  2  00 OFF, 01 DIRECT, 10 SCAN_UP, 11 SCAN_DOWN
- sel  in  SEL_W  direct select / scan start position
- load  in  1  in SCAN modes: jump position to sel
- dwell  in  DWELL_W  cycles per scan position = dwell+1
- res  out  OUT_W  active-low one-cold output, registered
- idx  out  SEL_W  current position, registered
- wrap  out  1  one-cycle pulse when scan wraps

## Operation
- Reset (rst=1 at a clock edge): res = all ones, idx = 0, wrap = 0, dwell counter = 0, state OFF. Reset wins over every other input.
- res is always derived from the registered state: in OFF it is all ones; in DIRECT/SCAN exactly bit idx is 0, all others 1.
- States follow mode, sampled every cycle: OFF, DIRECT, SCAN (mode 10 or 11; direction is mode[0]).
- OFF: idx holds, dwell counter cleared, wrap = 0.
- DIRECT: idx <= sel every cycle; dwell counter cleared; wrap = 0.
- SCAN: dwell counter increments each cycle; when counter >= dwell (compare live, so lowering dwell mid-dwell forces an advance on the next edge), counter <= 0 and idx advances by +1 (UP) or -1 (DOWN) modulo OUT_W.
- wrap = 1 for the cycle following an advance of OUT_W-1 -> 0 (UP) or 0 -> OUT_W-1 (DOWN); no wrap on load or on mode-entry.
- load in SCAN: idx <= sel, counter <= 0, no advance that cycle, no wrap; load has priority over advance. load ignored in OFF/DIRECT.
- Entering SCAN from OFF or DIRECT: scan starts from the held idx with counter at 0 (first position held dwell+1 cycles).
- Switching UP <-> DOWN mid-dwell: counter preserved, direction changes at next advance.
- dwell = 0: advance every cycle.
- SEL_W = 1: OUT_W = 2; wrap on every advance.

## Timing
- All outputs registered; latency from sel (DIRECT) or mode to res/idx is 1 cycle.
- Scan period per position = dwell+1 cycles; full sweep = OUT_W*(dwell+1) cycles.
- wrap asserted in the same cycle res shows the wrapped position.
- No combinational path input -> output.

## Structure
- Package lowdec_pkg: mode enum (MODE_OFF, MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DOWN), function for active-low one-cold encode of an index into OUT_W bits.
- Sub-module lowdec_dwell_timer: DWELL_W counter with clear, live terminal compare (>=), one-cycle tick output; top holds the state register, idx, res and wrap logic.

## Test plan
- Reset then DIRECT, SEL_W=3, sel=5 -> after 1 cycle res=8'b11011111, idx=5; sel sweep 0..7 reproduces 8'b11111110 .. 8'b01111111.
- OFF after DIRECT sel=2 -> res=8'hFF next cycle, idx stays 2; back to DIRECT sel=2 -> res=8'b11111011.
- SCAN_UP, dwell=2, start idx=6 -> idx 6,6,6,7,7,7,0 ...; wrap=1 exactly in first cycle idx=0, and res=8'b11111110 there.
- SCAN_DOWN, dwell=0, idx=1 -> idx 0 then 7 with wrap=1 on the 7 cycle; load with sel=4 while advancing -> idx=4, no wrap, then 3.
- SCAN_UP, dwell=10, counter at 7, dwell changed to 3 -> advance on the next edge; counter restarts and next dwell is 4 cycles.
- rst asserted mid-scan at idx=5 -> next cycle res=all ones, idx=0, wrap=0 regardless of mode/load.
